res_mem_arb: RTL and testbench
==============================

RES_MEM_ARB -- requirements
Module: res_mem_arb

Interface
REQ-001 Parameter ADDR_W, default 14, res memory address width (128x128 image).
REQ-002 Parameter DATA_W, default 8, res memory data width (distance value).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req0 / req1  input  1  access request from requester 0 (DT engine) / requester 1 (readout client).
REQ-006 wr0 / wr1  input  1  1 = write, 0 = read; qualified by reqN.
REQ-007 addr0 / addr1  input  ADDR_W  access address.
REQ-008 wdata0 / wdata1  input  DATA_W  write data.
REQ-009 lock0 / lock1  input  1  hold ownership after the current access (used only when RES_ARB_LOCK_EN is defined).
REQ-010 gnt0 / gnt1  output  1  access accepted this cycle.
REQ-011 rvalid0 / rvalid1  output  1  read data valid for that requester.
REQ-012 rdata  output  DATA_W  read data, shared by both requesters.
REQ-013 res_rd / res_wr  output  1  memory read / write strobe.
REQ-014 res_addr  output  ADDR_W  memory address.
REQ-015 res_do  output  DATA_W  memory write data.
REQ-016 res_di  input  DATA_W  memory read data, valid one cycle after res_rd.

Function
REQ-017 Accesses are single-beat; an access is transferred in the cycle where reqN=1 and gntN=1.
REQ-018 At most one gnt is high per cycle; gnt is combinational from req and the registered arbitration state.
REQ-019 FSM states: IDLE, OWN0, OWN1; state and pointer update on the rising clk edge.
REQ-020 IDLE or no ownership, one requester active: grant it.
REQ-021 IDLE or no ownership, both requesters active: grant the requester not granted most recently (round-robin pointer); the pointer resets to 1, so requester 0 wins the first tie.
REQ-022 The pointer updates only on a granted transfer.
REQ-023 Memory strobes are combinational from the granted requester: res_rd = gnt & ~wr; res_wr = gnt & wr; res_addr and res_do are the granted addr and wdata.
REQ-024 When no grant is given, res_rd = res_wr = 0 and res_addr = res_do = 0.
REQ-025 rvalidN is registered and rises in the cycle after a granted read by requester N; rdata = res_di in that cycle.
REQ-026 Total read latency is 1 cycle.
REQ-027 rvalid0 and rvalid1 are never high together.
REQ-028 Back-to-back granted reads produce back-to-back rvalid pulses.
REQ-029 A write produces no rvalid.
REQ-030 The block holds no write buffer; there is no full or empty condition; an ungranted requester holds its request stable until granted.

Reset
REQ-031 On reset low, all outputs go to 0 immediately; state goes to IDLE, the pointer to 1, and pending rvalid is cleared.
REQ-032 Reset asserted mid-access drops the access; no rvalid follows after reset release.

Configuration
REQ-033 With RES_ARB_LOCK_EN defined, a transfer by requester N with lockN=1 moves the FSM to OWNN.
REQ-034 In OWNN only requester N can be granted, even when the other requester is active.
REQ-035 The FSM leaves OWNN to IDLE on the first granted transfer by N with lockN=0, or in any cycle where reqN=0 and lockN=0.
REQ-036 Without RES_ARB_LOCK_EN, lock0/lock1 are ignored, the FSM never leaves IDLE, and arbitration is pure round-robin per beat.

Structure
REQ-037 A shared package holds ADDR_W and DATA_W defaults, the FSM state encoding, and the requester index constants.
REQ-038 A single sub-module, rr_pick2, computes the two-way round-robin selection from req, the pointer and the ownership mask.

Verification
REQ-039 Only req0 read of addr 14'h0081, res_di=8'h05 next cycle -> gnt0=1, res_rd=1, res_addr=14'h0081; next cycle rvalid0=1, rdata=8'h05.
REQ-040 req0 and req1 both held for 4 cycles with no lock -> grants alternate 0,1,0,1.
REQ-041 req1 write addr 14'h3F7F, data 8'h07 -> res_wr=1, res_addr=14'h3F7F, res_do=8'h07 in the same cycle; rvalid1 stays 0.
REQ-042 RES_ARB_LOCK_EN defined, req0 with lock0=1 for 3 beats then lock0=0, req1 held throughout -> gnt0 on 4 consecutive beats, then gnt1.
REQ-043 RES_ARB_LOCK_EN undefined, same stimulus as REQ-042 -> grants alternate 0,1,0,1,...
REQ-044 reset pulsed low in the cycle after a granted read -> rvalid stays 0; after release, first tie goes to requester 0.

Source files
------------

// File: rtl/res_mem_arb_pkg.sv
// rtl/res_mem_arb_pkg.sv - shared widths, FSM encoding and requester indices for res_mem_arb
package res_mem_arb_pkg;

  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 8;

  // Requester indices into the two-bit request/grant vectors
  localparam int REQ0 = 0;
  localparam int REQ1 = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/res_mem_arb_if.sv
// rtl/res_mem_arb_if.sv - requester and memory-side signal bundle for res_mem_arb
interface res_mem_arb_if
  import res_mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              req0;
  logic              wr0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              lock0;
  logic              req1;
  logic              wr1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              lock1;
  logic              gnt0;
  logic              gnt1;
  logic              rvalid0;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata;
  logic              res_rd;
  logic              res_wr;
  logic [ADDR_W-1:0] res_addr;
  logic [DATA_W-1:0] res_do;
  logic [DATA_W-1:0] res_di;

  // Requesters plus the memory returning res_di
  modport master (
    output req0, wr0, addr0, wdata0, lock0,
    output req1, wr1, addr1, wdata1, lock1,
    output res_di,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata,
    input  res_rd, res_wr, res_addr, res_do
  );

  // The arbiter itself
  modport slave (
    input  req0, wr0, addr0, wdata0, lock0,
    input  req1, wr1, addr1, wdata1, lock1,
    input  res_di,
    output gnt0, gnt1, rvalid0, rvalid1, rdata,
    output res_rd, res_wr, res_addr, res_do
  );

endinterface

// File: rtl/res_mem_arb_rr_pick2.sv
// rtl/res_mem_arb_rr_pick2.sv - two-way round-robin pick with ownership mask
module rr_pick2
  import res_mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,   // index of the most recently granted requester
  input  logic [1:0] mask,  // requesters allowed to win this cycle
  output logic [1:0] gnt
);

  logic [1:0] eff;

  assign eff = req & mask;

  // On a tie the requester that did not win last time takes the beat
  always_comb begin
    gnt = 2'b00;
    case (eff)
      2'b01:   gnt[REQ0] = 1'b1;
      2'b10:   gnt[REQ1] = 1'b1;
      2'b11: begin
        if (ptr) gnt[REQ0] = 1'b1;
        else     gnt[REQ1] = 1'b1;
      end
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/res_mem_arb.sv
// rtl/res_mem_arb.sv - two-requester res memory arbiter; optional ownership lock via RES_ARB_LOCK_EN
module res_mem_arb
  import res_mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
)(
  input  logic         clk,
  input  logic         reset,
  res_mem_arb_if.slave bus
);

  arb_state_t state;
  arb_state_t state_nxt;
  logic       ptr;
  logic       rv0;
  logic       rv1;
  logic [1:0] req_v;
  logic [1:0] mask;
  logic [1:0] pick;
  logic [1:0] gnt;

  assign req_v = {bus.req1, bus.req0};

  // An owner excludes the other requester; otherwise both may compete
  always_comb begin
    mask = 2'b11;
`ifdef RES_ARB_LOCK_EN
    case (state)
      ST_OWN0: mask = 2'b01;
      ST_OWN1: mask = 2'b10;
      default: mask = 2'b11;
    endcase
`endif
  end

  rr_pick2 u_pick (
    .req  (req_v),
    .ptr  (ptr),
    .mask (mask),
    .gnt  (pick)
  );

  // Grants are gated by reset so every output drops as soon as reset asserts
  assign gnt = pick & {2{reset}};

  assign bus.gnt0     = gnt[REQ0];
  assign bus.gnt1     = gnt[REQ1];
  assign bus.res_rd   = (gnt[REQ0] & ~bus.wr0) | (gnt[REQ1] & ~bus.wr1);
  assign bus.res_wr   = (gnt[REQ0] &  bus.wr0) | (gnt[REQ1] &  bus.wr1);
  assign bus.res_addr = gnt[REQ0] ? bus.addr0  : (gnt[REQ1] ? bus.addr1  : '0);
  assign bus.res_do   = gnt[REQ0] ? bus.wdata0 : (gnt[REQ1] ? bus.wdata1 : '0);
  assign bus.rvalid0  = rv0;
  assign bus.rvalid1  = rv1;
  assign bus.rdata    = (rv0 | rv1) ? bus.res_di : '0;

  // Pointer follows each granted beat; rvalid marks the cycle res_di is valid
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= 1'b1;
      rv0 <= 1'b0;
      rv1 <= 1'b0;
    end else begin
      if (gnt[REQ0])      ptr <= 1'b0;
      else if (gnt[REQ1]) ptr <= 1'b1;
      rv0 <= gnt[REQ0] & ~bus.wr0;
      rv1 <= gnt[REQ1] & ~bus.wr1;
    end
  end

  // Ownership state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

`ifdef RES_ARB_LOCK_EN
  // Enter ownership on a locked transfer; release on an unlocked transfer or an idle unlocked owner
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (gnt[REQ0] && bus.lock0)      state_nxt = ST_OWN0;
        else if (gnt[REQ1] && bus.lock1) state_nxt = ST_OWN1;
      end
      ST_OWN0: if (!bus.lock0 && (gnt[REQ0] || !bus.req0)) state_nxt = ST_IDLE;
      ST_OWN1: if (!bus.lock1 && (gnt[REQ1] || !bus.req1)) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end
`else
  logic unused_cfg;

  // Without locking the arbiter stays in IDLE and arbitrates every beat
  always_comb begin
    state_nxt = ST_IDLE;
  end

  assign unused_cfg = bus.lock0 ^ bus.lock1 ^ (state != ST_IDLE);
`endif

endmodule

// File: tb/tb_res_mem_arb.sv
// tb/tb_res_mem_arb.sv - randomized and directed bench for res_mem_arb against a rule-level model
module tb_res_mem_arb;
  import res_mem_arb_pkg::*;

  localparam int AW = 14;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;

  res_mem_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  res_mem_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: owner (-1 none), last granted requester, read pending per requester
  int m_own = -1;
  int m_last = 1;
  bit m_pv[2];

  // Stimulus for the next step
  logic          s_req[2];
  logic          s_wr[2];
  logic          s_lock[2];
  logic [AW-1:0] s_addr[2];
  logic [DW-1:0] s_wd[2];
  logic [DW-1:0] s_di;

  int model_g;
  int dut_g;
  int seq[5];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic setreq(input int n, input logic r, input logic w, input logic l,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    s_req[n] = r; s_wr[n] = w; s_lock[n] = l; s_addr[n] = a; s_wd[n] = d;
  endtask

  function automatic void model_reset();
    m_own = -1;
    m_last = 1;
    m_pv[0] = 1'b0;
    m_pv[1] = 1'b0;
  endfunction

  function automatic int model_pick();
    bit c0;
    bit c1;
    c0 = s_req[0] && (m_own != 1);
    c1 = s_req[1] && (m_own != 0);
    if (c0 && c1) return (m_last == 0) ? 1 : 0;
    if (c0) return 0;
    if (c1) return 1;
    return -1;
  endfunction

  function automatic void model_commit(input int g);
    m_pv[0] = (g == 0) && !s_wr[0];
    m_pv[1] = (g == 1) && !s_wr[1];
    if (g >= 0) m_last = g;
`ifdef RES_ARB_LOCK_EN
    if (g >= 0) m_own = s_lock[g] ? g : -1;
    else if (m_own >= 0 && !s_req[m_own] && !s_lock[m_own]) m_own = -1;
`endif
  endfunction

  // One clock of stimulus: drive after the falling edge, check, then advance the model
  task automatic step(input logic rst);
    int g;
    logic e_rd, e_wr, e_rv0, e_rv1;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_do, e_rdata;
    @(negedge clk);
    reset = rst;
    bus.req0 = s_req[0]; bus.wr0 = s_wr[0]; bus.addr0 = s_addr[0];
    bus.wdata0 = s_wd[0]; bus.lock0 = s_lock[0];
    bus.req1 = s_req[1]; bus.wr1 = s_wr[1]; bus.addr1 = s_addr[1];
    bus.wdata1 = s_wd[1]; bus.lock1 = s_lock[1];
    bus.res_di = s_di;
    #1;
    if (!rst) begin
      model_reset();
      g = -1;
    end else begin
      g = model_pick();
    end
    e_rv0 = m_pv[0] && rst;
    e_rv1 = m_pv[1] && rst;
    e_rd = 1'b0; e_wr = 1'b0; e_addr = '0; e_do = '0;
    if (g >= 0) begin
      e_rd = !s_wr[g]; e_wr = s_wr[g]; e_addr = s_addr[g]; e_do = s_wd[g];
    end
    e_rdata = (e_rv0 || e_rv1) ? s_di : '0;
    chk("gnt0", 32'(bus.gnt0), 32'(g == 0));
    chk("gnt1", 32'(bus.gnt1), 32'(g == 1));
    chk("res_rd", 32'(bus.res_rd), 32'(e_rd));
    chk("res_wr", 32'(bus.res_wr), 32'(e_wr));
    chk("res_addr", 32'(bus.res_addr), 32'(e_addr));
    chk("res_do", 32'(bus.res_do), 32'(e_do));
    chk("rvalid0", 32'(bus.rvalid0), 32'(e_rv0));
    chk("rvalid1", 32'(bus.rvalid1), 32'(e_rv1));
    chk("rdata", 32'(bus.rdata), 32'(e_rdata));
    dut_g = bus.gnt0 ? 0 : (bus.gnt1 ? 1 : -1);
    model_g = g;
    if (rst) model_commit(g);
  endtask

  initial begin
    int exp_seq[5];
    setreq(0, 1'b0, 1'b0, 1'b0, '0, '0);
    setreq(1, 1'b0, 1'b0, 1'b0, '0, '0);
    s_di = '0;

    // Reset held with both requesters active: everything stays 0
    setreq(0, 1'b1, 1'b0, 1'b0, 14'h0011, 8'h11);
    setreq(1, 1'b1, 1'b1, 1'b0, 14'h0022, 8'h22);
    step(1'b0);
    step(1'b0);

    // Tie held for 4 beats after reset: 0,1,0,1
    setreq(0, 1'b1, 1'b0, 1'b0, 14'h0100, 8'h00);
    setreq(1, 1'b1, 1'b0, 1'b0, 14'h0200, 8'h00);
    for (int i = 0; i < 4; i++) begin
      s_di = DW'(8'h30 + i);
      step(1'b1);
      seq[i] = dut_g;
    end
    for (int i = 0; i < 4; i++) chk($sformatf("rr_tie_%0d", i), 32'(seq[i]), 32'(i % 2));

    // Single read by requester 0, data returned next cycle
    setreq(1, 1'b0, 1'b0, 1'b0, '0, '0);
    setreq(0, 1'b1, 1'b0, 1'b0, 14'h0081, 8'h00);
    step(1'b1);
    chk("rd0_addr", 32'(bus.res_addr), 32'h0081);
    setreq(0, 1'b0, 1'b0, 1'b0, '0, '0);
    s_di = 8'h05;
    step(1'b1);
    chk("rd0_rvalid", 32'(bus.rvalid0), 32'h1);
    chk("rd0_rdata", 32'(bus.rdata), 32'h05);

    // Write by requester 1: strobes in the same cycle, no rvalid after
    setreq(1, 1'b1, 1'b1, 1'b0, 14'h3F7F, 8'h07);
    step(1'b1);
    chk("wr1_addr", 32'(bus.res_addr), 32'h3F7F);
    chk("wr1_do", 32'(bus.res_do), 32'h07);
    setreq(1, 1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b1);
    chk("wr1_no_rvalid", 32'(bus.rvalid1), 32'h0);

    // Lock sequence from a fresh pointer: lock0 for 3 beats, then released
    step(1'b0);
`ifdef RES_ARB_LOCK_EN
    exp_seq = '{0, 0, 0, 0, 1};
`else
    exp_seq = '{0, 1, 0, 1, 0};
`endif
    setreq(1, 1'b1, 1'b0, 1'b0, 14'h0400, 8'h00);
    for (int i = 0; i < 5; i++) begin
      setreq(0, 1'b1, 1'b0, (i < 3) ? 1'b1 : 1'b0, 14'h0300, 8'h00);
      step(1'b1);
      seq[i] = dut_g;
    end
    for (int i = 0; i < 5; i++) chk($sformatf("lock_seq_%0d", i), 32'(seq[i]), 32'(exp_seq[i]));

    // Reset dropped in the wake of a granted read: no rvalid, then first tie goes to 0
    setreq(1, 1'b0, 1'b0, 1'b0, '0, '0);
    setreq(0, 1'b1, 1'b0, 1'b0, 14'h0055, 8'h00);
    step(1'b1);
    #2 reset = 1'b0;
    model_reset();
    step(1'b0);
    chk("rst_rvalid0", 32'(bus.rvalid0), 32'h0);
    setreq(1, 1'b1, 1'b0, 1'b0, 14'h0066, 8'h00);
    step(1'b1);
    chk("rst_first_tie", 32'(dut_g), 32'h0);

    // Randomized traffic: an ungranted request is held unchanged until granted
    for (int i = 0; i < 400; i++) begin
      for (int n = 0; n < 2; n++) begin
        if (!s_req[n] || model_g == n) begin
          setreq(n, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'b0,
                 AW'($urandom), DW'($urandom));
        end
        s_lock[n] = ($urandom_range(0, 2) == 0);
      end
      s_di = DW'($urandom);
      step(($urandom_range(0, 79) == 0) ? 1'b0 : 1'b1);
      if (!reset) model_g = -1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
